// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups the two handshakes of the fetch stage.
//   System bus : bus_reqcyc/bus_req/bus_reqtag/bus_reqack (request),
//                bus_respcyc/bus_resp/bus_resptag/bus_respack (response beats)
//   Decoder    : instr/instr_pc/instr_valid/instr_ready
// Modport master is the fetch stage; modport slave is the bus + decoder side.
interface fetch_unit_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13
);
  logic              bus_reqcyc;
  logic [DATA_W-1:0] bus_req;
  logic [TAG_W-1:0]  bus_reqtag;
  logic              bus_reqack;
  logic              bus_respcyc;
  logic [DATA_W-1:0] bus_resp;
  logic [TAG_W-1:0]  bus_resptag;
  logic              bus_respack;
  logic [31:0]       instr;
  logic [63:0]       instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  modport master (
    output bus_reqcyc, bus_req, bus_reqtag,
    input  bus_reqack,
    input  bus_respcyc, bus_resp, bus_resptag,
    output bus_respack,
    output instr, instr_pc, instr_valid,
    input  instr_ready
  );

  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag,
    output bus_reqack,
    output bus_respcyc, bus_resp, bus_resptag,
    input  bus_respack,
    input  instr, instr_pc, instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of the decoder.
// Reads one line (LINE_BEATS beats of 64 bits) per bus request, buffers it,
// and hands out one 32-bit instruction per decoder handshake with its PC.
// Ports:
//   clk, reset      system clock, async active-high reset
//   entry           start PC, sampled while reset is high
//   bus             fetch_unit_if.master (system bus + decoder handshake)
//   redirect(_pc)   PC replacement from later stages
//   halted          an all-zero instruction was consumed; fetch stopped
//
// state   | meaning
// S_REQ   | line request on the bus, waiting for bus_reqack
// S_RESP  | collecting response beats into the line buffer
// S_DRAIN | presenting buffered words to the decoder
// S_HALT  | zero instruction consumed; idle until reset
module fetch_unit #(
  parameter int                       BUS_DATA_WIDTH = 64,
  parameter int                       BUS_TAG_WIDTH  = 13,
  parameter int                       LINE_BEATS     = 8,
  parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG       = 13'h1100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [63:0]         entry,
  fetch_unit_if.master        bus,
  input  logic                redirect,
  input  logic [63:0]         redirect_pc,
  output logic                halted
);

  localparam int WORD_W = $clog2(LINE_BEATS * 2);
  localparam int OFF_W  = WORD_W + 2;
  localparam int BEAT_W = $clog2(LINE_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  typedef enum logic [1:0] {S_REQ, S_RESP, S_DRAIN, S_HALT} state_t;

  state_t                    state_q;
  logic [63:0]               pc_q;
  logic                      discard_q;
  logic [BEAT_W-1:0]         beat_q;
  logic [BUS_DATA_WIDTH-1:0] buf_q [LINE_BEATS];
  logic                      reqcyc_q;
  logic [63:0]               req_q;
  logic [31:0]               instr_q;
  logic [63:0]               instr_pc_q;
  logic                      valid_q;
  logic                      halted_q;

  function automatic logic [63:0] line_addr(input logic [63:0] a);
    return {a[63:OFF_W], {OFF_W{1'b0}}};
  endfunction

  // Little-endian: the even word of a beat is its low half.
  function automatic logic [31:0] pick_word(input logic [63:0] beat, input logic hi);
    return hi ? beat[63:32] : beat[31:0];
  endfunction

  logic [63:0]       pc_plus4_d;
  logic [63:0]       redirect_al_d;
  logic [BEAT_W-1:0] next_beat_d;
  logic [31:0]       next_word_d;
  logic [BEAT_W-1:0] first_beat_idx_d;
  logic [63:0]       first_beat_d;
  logic              unused_resptag;

  assign pc_plus4_d    = pc_q + 64'd4;
  assign redirect_al_d = redirect_pc & ~64'h3;
  assign next_beat_d   = pc_plus4_d[OFF_W-1:3];
  assign next_word_d   = pick_word(buf_q[next_beat_d], pc_plus4_d[2]);

  // The first word handed out may live in the beat arriving this very cycle,
  // so bypass the buffer for the last beat.
  assign first_beat_idx_d = pc_q[OFF_W-1:3];
  assign first_beat_d     = (first_beat_idx_d == LAST_BEAT) ? bus.bus_resp
                                                            : buf_q[first_beat_idx_d];

  assign unused_resptag = ^bus.bus_resptag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= entry & ~64'h3;
      discard_q  <= 1'b0;
      beat_q     <= '0;
      reqcyc_q   <= 1'b0;
      req_q      <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      for (int i = 0; i < LINE_BEATS; i++) buf_q[i] <= '0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (!reqcyc_q) begin
            // Only reached in the first cycle after reset; all other entries
            // into S_REQ raise the request directly.
            reqcyc_q <= 1'b1;
            if (redirect) begin
              pc_q  <= redirect_al_d;
              req_q <= line_addr(redirect_al_d);
            end else begin
              req_q <= line_addr(pc_q);
            end
          end else begin
            // The request already on the bus cannot be withdrawn, so a
            // redirect only marks the coming burst as garbage.
            if (redirect) begin
              pc_q      <= redirect_al_d;
              discard_q <= 1'b1;
            end
            if (bus.bus_reqack) begin
              reqcyc_q <= 1'b0;
              beat_q   <= '0;
              state_q  <= S_RESP;
            end
          end
        end

        S_RESP: begin
          if (redirect) begin
            pc_q      <= redirect_al_d;
            discard_q <= 1'b1;
          end
          if (bus.bus_respcyc) begin
            buf_q[beat_q] <= bus.bus_resp;
            beat_q        <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT) begin
              if (discard_q || redirect) begin
                discard_q <= 1'b0;
                state_q   <= S_REQ;
                reqcyc_q  <= 1'b1;
                req_q     <= line_addr(redirect ? redirect_al_d : pc_q);
              end else begin
                state_q    <= S_DRAIN;
                valid_q    <= 1'b1;
                instr_q    <= pick_word(first_beat_d, pc_q[2]);
                instr_pc_q <= pc_q;
              end
            end
          end
        end

        S_DRAIN: begin
          if (redirect) begin
            // A word accepted in this same cycle is consumed, but pc follows
            // the redirect rather than advancing.
            pc_q     <= redirect_al_d;
            valid_q  <= 1'b0;
            state_q  <= S_REQ;
            reqcyc_q <= 1'b1;
            req_q    <= line_addr(redirect_al_d);
          end else if (valid_q && bus.instr_ready) begin
            if (instr_q == 32'h0) begin
              valid_q  <= 1'b0;
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end else begin
              pc_q <= pc_plus4_d;
              if (pc_q[OFF_W-1:2] == '1) begin
                valid_q  <= 1'b0;
                state_q  <= S_REQ;
                reqcyc_q <= 1'b1;
                req_q    <= line_addr(pc_plus4_d);
              end else begin
                instr_q    <= next_word_d;
                instr_pc_q <= pc_plus4_d;
              end
            end
          end
        end

        default: ;
      endcase
    end
  end

  assign bus.bus_reqcyc  = reqcyc_q;
  assign bus.bus_req     = req_q;
  assign bus.bus_reqtag  = reqcyc_q ? READ_TAG : '0;
  assign bus.bus_respack = (state_q == S_RESP) && bus.bus_respcyc;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign halted          = halted_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the decoder.
- Reads 64-byte instruction lines from memory over the system bus as 8 beats of 64 bits.
- Buffers each line and presents one 32-bit instruction per handshake to the decoder, together with its PC.
- Supports PC redirect from later stages, and halts on an all-zero instruction word.

Parameters:
BUS_DATA_WIDTH, 64, width of bus_req/bus_resp
BUS_TAG_WIDTH, 13, width of bus_reqtag/bus_resptag
LINE_BEATS, 8, response beats per line (line = LINE_BEATS*8 bytes)
READ_TAG, 13'h1100, tag driven on every fetch request (memory read)

Ports:
clk  in  1  system clock, all state on posedge
reset  in  1  asynchronous, active-high reset
entry  in  64  initial PC, sampled while reset is high
bus_reqcyc  out  1  request valid
bus_req  out  64  line-aligned request address
bus_reqtag  out  13  request tag
bus_reqack  in  1  request accepted by bus
bus_respcyc  in  1  response beat valid
bus_resp  in  64  response beat data
bus_resptag  in  13  response tag (ignored)
bus_respack  out  1  beat consumed
instr  out  32  instruction to decoder
instr_pc  out  64  PC of instr
instr_valid  out  1  instr/instr_pc valid
instr_ready  in  1  decoder accepts instr
redirect  in  1  replace fetch PC
redirect_pc  in  64  new PC; bits [1:0] forced to 0
halted  out  1  all-zero instruction consumed; fetch stopped

Behaviour:
- Reset (async, active-high):
  - All outputs are 0.
  - pc <= {entry[63:2],2'b00}; discard <= 0; state = REQ.
  - Reset mid-burst abandons the burst; remaining beats are not acked.
- States and transitions:
  - REQ: bus_reqcyc=1, bus_req={pc[63:6],6'b0}, bus_reqtag=READ_TAG. Outputs are held stable until bus_reqack. On ack: next cycle reqcyc=0, state -> RESP, beat counter = 0.
  - RESP: bus_respack = bus_respcyc (combinational, same cycle).
    - Each beat k is stored in buf[k]; the counter increments per beat.
    - After beat LINE_BEATS-1: -> REQ if discard (clear discard), else -> DRAIN.
    - No timeout.
  - DRAIN: instr_valid=1 with instr = word pc[5:2] of the line.
    - Word w = buf[w>>1][31:0] if w even, else [63:32] (little-endian).
    - instr_pc = pc.
    - instr and instr_pc are held stable while instr_valid=1 && instr_ready=0.
    - On valid&&ready: pc <= pc+4, instr_valid stays 1 with the next word. If pc[5:2] was 15 -> REQ, valid drops next cycle.
    - If the accepted instr == 32'h0 -> HALT.
  - HALT: halted=1, instr_valid=0, no bus requests. Only reset exits.
- Latency:
  - reqcyc is 1 in the first cycle after reset deassertion.
  - The first instr_valid is 1 cycle after the last beat is acked.
  - Line-internal throughput: 1 instruction per cycle with ready held high.
- Redirect (priority over all other events except reset; ignored in HALT):
  - pc <= {redirect_pc[63:2],2'b00}.
  - In DRAIN: instr_valid=0 next cycle, -> REQ. A simultaneous valid&&ready counts as consumed but does not advance pc.
  - In REQ before ack, or in RESP: set discard. The in-flight request/burst completes (bus cannot abort), beats are acked and dropped, then -> REQ at the new pc.
  - Redirect in the REQ ack cycle: same as RESP (discard).
  - Multiple redirects while discard is set: the last one wins.
- Wrap-around: pc+4 wraps modulo 2^64. A redirect_pc mid-line starts delivery at that word; earlier words of the line are skipped.
- bus_resptag is not checked. Exactly LINE_BEATS respcyc beats are expected per request.

Test Plan:
1. entry=0x1000, memory words at 0x1000.. = 0x00000013 (x15), 0x00000000 at 0x103C; instr_ready=1 -> one request at 0x1000 with tag 0x1100; instr_pc 0x1000..0x1038 in consecutive cycles; halted=1 after 0x103C; no second request.
2. entry=0x2034, ready=1 -> request address 0x2000; only words 0x2034, 0x2038, 0x203C delivered; next request at 0x2040.
3. instr_ready toggles 1/0 randomly during DRAIN -> instr/instr_pc never change while valid=1 && ready=0; no word dropped or duplicated.
4. redirect=1, redirect_pc=0x3006 during RESP beat 3 -> remaining beats acked, no instr_valid from that line; next request 0x3000; first instr_pc=0x3004.
5. redirect during DRAIN coinciding with valid&&ready -> instr_valid=0 next cycle; next request is the redirect line.
6. reset asserted mid-burst with entry=0x4000 -> all outputs 0 immediately; reqcyc=1 with bus_req=0x4000 the cycle after release.
